peri_timer_resp: RTL and testbench

Peripheral-side responder for the peripheral bus. It accepts the one-cycle fanned-out rden/wren strobes, address, wdata and wstrb from the bus, and returns a one-hot-compatible ready pulse with rdata. It implements a prescaled down-counting timer with auto-reload and an interrupt, occupying one peripheral slot, for example the CSR slot selected by addr[19:16]=4.

---
 rtl/peri_timer_resp.sv | 166 ++++++++++++++++
 tb/tb_peri_timer_resp.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/peri_timer_resp.sv
// Peripheral-bus responder hosting a prescaled down-counting timer with
// auto-reload and a level interrupt. Every strobe is acknowledged with a
// one-cycle ready pulse exactly one cycle later; reads return the register
// value as it stood before the sampling edge.
module peri_timer_resp #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr_2peri,
  input  logic        i_wren_2peri,
  input  logic        i_rden_2peri,
  input  logic [31:0] i_wdata_2peri,
  input  logic [3:0]  i_wstrb_2peri,
  output logic        o_ready_2PBUS,
  output logic [31:0] o_rdata_2PBUS,
  output logic        o_irq
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_LOAD     = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  // Architectural state
  logic             en, auto_reload, irq_en, expired;
  logic [PRE_W-1:0] prescale, pre_cnt;
  logic [CNT_W-1:0] load, count;

  // Next-state values
  logic             en_n, auto_reload_n, irq_en_n, expired_n;
  logic [PRE_W-1:0] prescale_n, pre_cnt_n;
  logic [CNT_W-1:0] load_n, count_n;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // A simultaneous read and write is handled purely as a write.
  logic       wr, rd;
  logic [2:0] sel;
  assign wr  = i_wren_2peri;
  assign rd  = i_rden_2peri & ~i_wren_2peri;
  assign sel = i_addr_2peri[4:2];

  logic ctrl_wr, pre_wr, load_wr, stat_wr;
  assign ctrl_wr = wr && (sel == REG_CTRL);
  assign pre_wr  = wr && (sel == REG_PRESCALE);
  assign load_wr = wr && (sel == REG_LOAD);
  assign stat_wr = wr && (sel == REG_STATUS);

  logic [31:0] ctrl_word, ctrl_m, pre_m, load_m, stat_m;
  assign ctrl_word = {29'b0, irq_en, auto_reload, en};
  assign ctrl_m    = merge_lanes(ctrl_word, i_wdata_2peri, i_wstrb_2peri);
  assign pre_m     = merge_lanes(32'(prescale), i_wdata_2peri, i_wstrb_2peri);
  assign load_m    = merge_lanes(32'(load), i_wdata_2peri, i_wstrb_2peri);
  assign stat_m    = i_wdata_2peri & {{24{i_wstrb_2peri[3]}}, {8{i_wstrb_2peri[2]}},
                                      {8{i_wstrb_2peri[1]}}, {8{i_wstrb_2peri[0]}}};

  // Address bits outside [4:2] and upper merged bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{i_addr_2peri[31:5], i_addr_2peri[1:0], ctrl_m, pre_m, load_m, stat_m};

  // A LOAD write voids any tick in the same cycle.
  logic tick, expire;
  assign tick   = en && (pre_cnt == prescale) && !load_wr;
  assign expire = tick && (count == '0);

  // Timer and register next-state; later assignments take priority.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    en_n          = en;
    auto_reload_n = auto_reload;
    irq_en_n      = irq_en;
    expired_n     = expired;
    prescale_n    = prescale;
    load_n        = load;
    count_n       = count;
    pre_cnt_n     = pre_cnt;

    if (en) pre_cnt_n = (pre_cnt == prescale) ? '0 : pre_cnt + 1'b1;

    if (tick) begin
      if (count != '0) begin
        count_n = count - 1'b1;
      end else if (auto_reload) begin
        count_n = load;
      end else begin
        en_n = 1'b0;
      end
    end

    if (stat_wr && stat_m[0]) expired_n = 1'b0;
    if (expire)               expired_n = 1'b1;

    if (pre_wr) prescale_n = pre_m[PRE_W-1:0];

    if (load_wr) begin
      load_n    = load_m[CNT_W-1:0];
      count_n   = load_m[CNT_W-1:0];
      pre_cnt_n = '0;
    end

    if (ctrl_wr) begin
      en_n          = ctrl_m[0];
      auto_reload_n = ctrl_m[1];
      irq_en_n      = ctrl_m[2];
      if (!en && ctrl_m[0]) pre_cnt_n = '0;
    end
  end

  // Read mux over pre-edge register values.
  logic [31:0] rd_val;
  always_comb begin
    rd_val = '0;
    case (sel)
      REG_CTRL:     rd_val = ctrl_word;
      REG_PRESCALE: rd_val = 32'(prescale);
      REG_LOAD:     rd_val = 32'(load);
      REG_COUNT:    rd_val = 32'(count);
      REG_STATUS:   rd_val = {31'b0, expired};
      default:      rd_val = '0;
    endcase
  end

  // State registers, bus response and registered interrupt.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      en            <= 1'b0;
      auto_reload   <= 1'b0;
      irq_en        <= 1'b0;
      expired       <= 1'b0;
      prescale      <= '0;
      pre_cnt       <= '0;
      load          <= '0;
      count         <= '0;
      o_ready_2PBUS <= 1'b0;
      o_rdata_2PBUS <= '0;
      o_irq         <= 1'b0;
    end else begin
      en            <= en_n;
      auto_reload   <= auto_reload_n;
      irq_en        <= irq_en_n;
      expired       <= expired_n;
      prescale      <= prescale_n;
      pre_cnt       <= pre_cnt_n;
      load          <= load_n;
      count         <= count_n;
      o_ready_2PBUS <= i_rden_2peri | i_wren_2peri;
      o_rdata_2PBUS <= rd ? rd_val : 32'h0;
      o_irq         <= expired & irq_en;
    end
  end

endmodule

// File: tb/tb_peri_timer_resp.sv
// Directed bench for peri_timer_resp. Each access pushes its expected rdata
// onto a scoreboard; a monitor pops and compares when ready is observed.
module tb_peri_timer_resp;

  localparam logic [31:0] A_CTRL = 32'h0, A_PRE = 32'h4, A_LOAD = 32'h8,
                          A_COUNT = 32'hC, A_STAT = 32'h10, A_UNMAP = 32'h18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        irq;

  peri_timer_resp #(.CNT_W(32), .PRE_W(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_addr_2peri  (addr),
    .i_wren_2peri  (wren),
    .i_rden_2peri  (rden),
    .i_wdata_2peri (wdata),
    .i_wstrb_2peri (wstrb),
    .o_ready_2PBUS (ready),
    .o_rdata_2PBUS (rdata),
    .o_irq         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic mon_on = 1'b0;
  logic exp_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Track which edges sampled an access; a reset edge drops it.
  always @(posedge clk) begin
    if (rst) begin
      if ((rden || wren) && sb.size() > 0) void'(sb.pop_front());
      exp_rdy = 1'b0;
    end else begin
      exp_rdy = rden || wren;
    end
  end

  // Compare ready and rdata mid-cycle against the scoreboard.
  always @(negedge clk) begin
    if (mon_on) begin
      check("ready", 32'(ready), 32'(exp_rdy));
      if (exp_rdy) begin
        if (sb.size() == 0) begin
          check("sb_pending", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check(e.tag, rdata, e.data);
        end
      end else begin
        check("rdata_idle", rdata, 32'h0);
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp, input string tag);
    rden = rd; wren = wr; addr = a; wdata = d; wstrb = s;
    if (rd || wr) sb.push_back('{tag: tag, data: (rd && !wr) ? exp : 32'h0});
    @(posedge clk); #1;
    rden = 1'b0; wren = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a, input logic [31:0] exp, input string tag);
    access(1'b1, 1'b0, a, 32'h0, 4'h0, exp, tag);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    access(1'b0, 1'b1, a, d, s, 32'h0, "wr_ack");
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    mon_on = 1'b1;
    rd_reg(A_CTRL,  32'h0, "rst_ctrl");
    rd_reg(A_PRE,   32'h0, "rst_pre");
    rd_reg(A_LOAD,  32'h0, "rst_load");
    rd_reg(A_COUNT, 32'h0, "rst_count");
    rd_reg(A_STAT,  32'h0, "rst_status");

    // Byte-lane merge on LOAD, mirrored into COUNT
    wr_reg(A_LOAD, 32'hAABBCCDD, 4'b1111);
    wr_reg(A_LOAD, 32'h11223344, 4'b0101);
    rd_reg(A_LOAD,  32'hAA22CC44, "lane_load");
    rd_reg(A_COUNT, 32'hAA22CC44, "lane_count");

    // One-shot: prescale 2 gives a tick every third cycle
    wr_reg(A_PRE, 32'd2, 4'hF);
    wr_reg(A_LOAD, 32'd3, 4'hF);
    wr_reg(A_CTRL, 32'h5, 4'hF);
    rd_reg(A_COUNT, 32'd3, "os_count3");
    idle(2);
    rd_reg(A_COUNT, 32'd2, "os_count2");
    idle(2);
    rd_reg(A_COUNT, 32'd1, "os_count1");
    idle(2);
    rd_reg(A_COUNT, 32'd0, "os_count0");
    rd_reg(A_STAT,  32'd0, "os_not_expired");
    idle(1);
    check("os_irq_lag", 32'(irq), 32'h0);
    rd_reg(A_STAT, 32'd1, "os_expired");
    check("os_irq_high", 32'(irq), 32'h1);
    rd_reg(A_CTRL, 32'h4, "os_en_cleared");
    idle(4);
    rd_reg(A_COUNT, 32'd0, "os_count_hold");
    wr_reg(A_STAT, 32'h1, 4'hF);
    check("w1c_irq_lag", 32'(irq), 32'h1);
    idle(1);
    check("w1c_irq_low", 32'(irq), 32'h0);
    rd_reg(A_STAT, 32'd0, "w1c_cleared");

    // Auto-reload: prescale 0, load 1 -> expire every second cycle
    wr_reg(A_PRE, 32'd0, 4'hF);
    wr_reg(A_LOAD, 32'd1, 4'hF);
    wr_reg(A_CTRL, 32'h3, 4'hF);
    rd_reg(A_COUNT, 32'd1, "ar_count_a");
    rd_reg(A_COUNT, 32'd0, "ar_count_b");
    rd_reg(A_COUNT, 32'd1, "ar_count_c");
    rd_reg(A_COUNT, 32'd0, "ar_count_d");
    rd_reg(A_STAT,  32'd1, "ar_expired");
    wr_reg(A_STAT, 32'h1, 4'hF);
    rd_reg(A_STAT,  32'd1, "ar_set_wins");
    wr_reg(A_CTRL, 32'h0, 4'hF);
    check("ar_irq_masked", 32'(irq), 32'h0);

    // Bus edge cases: back-to-back reads, rd+wr, empty strobe, unmapped
    wr_reg(A_PRE, 32'h1234, 4'hF);
    rd_reg(A_PRE,  32'h1234, "b2b_pre");
    rd_reg(A_LOAD, 32'd1,    "b2b_load");
    rd_reg(A_CTRL, 32'h0,    "b2b_ctrl");
    access(1'b1, 1'b1, A_LOAD, 32'd5, 4'hF, 32'h0, "rdwr_ack");
    wr_reg(A_LOAD, 32'hFFFF_FFFF, 4'b0000);
    rd_reg(A_LOAD,  32'd5, "rdwr_load");
    rd_reg(A_COUNT, 32'd5, "rdwr_count");
    rd_reg(A_UNMAP, 32'h0, "unmapped");

    // Reset sampled together with a read: the read is never acknowledged
    rst = 1'b1;
    rd_reg(A_LOAD, 32'd5, "rst_inflight");
    rst = 1'b0;
    idle(1);
    rd_reg(A_LOAD, 32'h0, "post_rst_load");
    rd_reg(A_PRE,  32'h0, "post_rst_pre");

    idle(2);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
